// File: rtl/fifo_rd_stream_if.sv
// Output stream of the FIFO read-side consumer: registered valid/ready with data.
// The master drives data/valid, the slave drives ready.
interface fifo_rd_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] O_DATA;
    logic                  O_VALID;
    logic                  O_READY;

    // A word transfers on a rising edge where O_VALID and O_READY are both 1.
    // Once O_VALID rises, O_VALID and O_DATA hold until that transfer (or a flush).
    modport master (
        output O_DATA,
        output O_VALID,
        input  O_READY
    );

    modport slave (
        input  O_DATA,
        input  O_VALID,
        output O_READY
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-domain consumer: drains the async FIFO into a 2-entry registered
// valid/ready buffer and keeps a saturating count of delivered words.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  R_CLK,
    input  logic                  R_RST,
    input  logic                  R_EMPTY,
    input  logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  R_INC,
    input  logic                  FLUSH,
    fifo_rd_stream_if.master      o_stream,
    output logic [CNT_WIDTH-1:0]  O_WORDS,
    output logic [1:0]            DBG_COUNT
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    occ_t                  count, count_d;
    logic [DATA_WIDTH-1:0] slot0, slot0_d;
    logic [DATA_WIDTH-1:0] slot1, slot1_d;
    logic                  push;
    logic                  pop_out;
    logic                  valid;

    // State register
    always_ff @(posedge R_CLK or negedge R_RST) begin
        if (!R_RST) begin
            count <= OCC_EMPTY;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            count <= count_d;
            slot0 <= slot0_d;
            slot1 <= slot1_d;
        end
    end

    // Next-state logic; flush wins over any push or pop in the same cycle
    always_comb begin
        count_d = count;
        slot0_d = slot0;
        slot1_d = slot1;
        if (FLUSH) begin
            count_d = OCC_EMPTY;
        end else begin
            case (count)
                OCC_EMPTY: begin
                    if (push) begin
                        slot0_d = RD_DATA;
                        count_d = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && pop_out) begin
                        slot0_d = RD_DATA;
                    end else if (push) begin
                        slot1_d = RD_DATA;
                        count_d = OCC_FULL;
                    end else if (pop_out) begin
                        count_d = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (pop_out) begin
                        slot0_d = slot1;
                        count_d = OCC_ONE;
                    end
                end
                default: count_d = OCC_EMPTY;
            endcase
        end
    end

    // Outputs: R_INC depends only on registers, R_EMPTY and FLUSH, never on O_READY
    always_comb begin
        valid   = (count != OCC_EMPTY);
        R_INC   = !R_EMPTY && (count != OCC_FULL) && !FLUSH;
        push    = R_INC;
        pop_out = valid && o_stream.O_READY;
    end

    assign o_stream.O_VALID = valid;
    assign o_stream.O_DATA  = slot0;
    assign DBG_COUNT        = count;

    // Counts every completed transfer, including one coinciding with a flush
    always_ff @(posedge R_CLK or negedge R_RST) begin
        if (!R_RST) begin
            O_WORDS <= '0;
        end else if (pop_out && (O_WORDS != {CNT_WIDTH{1'b1}})) begin
            O_WORDS <= O_WORDS + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: directed scenarios plus random traffic, checked
// against a queue-based model of the FIFO and the 2-word output buffer.
module tb_fifo_rd_stream;

    localparam int DW = 8;

    logic          r_clk = 1'b0;
    logic          r_rst;
    logic          r_empty;
    logic [DW-1:0] rd_data;
    logic          flush;
    logic          o_ready;
    logic          r_inc, r_inc2;
    logic [15:0]   words1;
    logic [1:0]    words2;
    logic [1:0]    dbg1, dbg2;

    fifo_rd_stream_if #(.DATA_WIDTH(DW)) s1 ();
    fifo_rd_stream_if #(.DATA_WIDTH(DW)) s2 ();
    assign s1.O_READY = o_ready;
    assign s2.O_READY = o_ready;

    fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
        .R_CLK(r_clk), .R_RST(r_rst), .R_EMPTY(r_empty), .RD_DATA(rd_data),
        .R_INC(r_inc), .FLUSH(flush), .o_stream(s1), .O_WORDS(words1),
        .DBG_COUNT(dbg1)
    );

    // Narrow-counter copy sharing all inputs, for saturation behaviour
    fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(2)) dut_sat (
        .R_CLK(r_clk), .R_RST(r_rst), .R_EMPTY(r_empty), .RD_DATA(rd_data),
        .R_INC(r_inc2), .FLUSH(flush), .o_stream(s2), .O_WORDS(words2),
        .DBG_COUNT(dbg2)
    );

    always #5 r_clk = ~r_clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] buf_q[$];
    logic [DW-1:0] delivered[$];
    logic [1:0]    sat_log[$];
    int            model_words;
    int            inc_pulses;
    bit            sat_en;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model
    task automatic step(input logic rdy, input logic fl);
        bit            exp_inc, exp_pop;
        logic [DW-1:0] word;
        o_ready = rdy;
        flush   = fl;
        r_empty = (fifo_q.size() == 0);
        rd_data = r_empty ? '0 : fifo_q[0];
        #1;
        exp_pop = (buf_q.size() != 0) && rdy;
        exp_inc = (fifo_q.size() != 0) && (buf_q.size() < 2) && !fl;
        check("r_inc", r_inc, exp_inc);
        check("r_inc_sat", r_inc2, exp_inc);
        check("o_valid", s1.O_VALID, buf_q.size() != 0);
        if (buf_q.size() != 0) check("o_data", s1.O_DATA, buf_q[0]);
        check("o_words", words1, model_words);
        check("o_words_sat", words2, (model_words > 3) ? 3 : model_words);
        if (r_inc) inc_pulses++;
        if (s1.O_VALID && rdy) delivered.push_back(s1.O_DATA);
        @(posedge r_clk);
        word = '0;
        if (exp_inc) word = fifo_q.pop_front();
        if (exp_pop && model_words < 65535) model_words++;
        if (fl) begin
            buf_q.delete();
        end else begin
            if (exp_pop) void'(buf_q.pop_front());
            if (exp_inc) buf_q.push_back(word);
        end
        #1;
        if (sat_en && exp_pop && sat_log.size() < 5) sat_log.push_back(words2);
    endtask

    logic [1:0] sat_exp [5];

    initial begin
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        r_rst = 1'b0; r_empty = 1'b1; rd_data = '0; flush = 1'b0; o_ready = 1'b0;
        model_words = 0; inc_pulses = 0; sat_en = 1'b1;

        // Reset state
        #1;
        check("rst_valid", s1.O_VALID, 1'b0);
        check("rst_data", s1.O_DATA, 8'h00);
        check("rst_words", words1, 16'd0);
        check("rst_inc", r_inc, 1'b0);
        repeat (2) @(posedge r_clk);
        #1 r_rst = 1'b1;
        for (int i = 0; i < 5; i++) step($urandom_range(0, 1), 1'b0);

        // Streaming three words
        fifo_q = '{8'h11, 8'h22, 8'h33};
        inc_pulses = 0; delivered.delete();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        check("stream_incs", inc_pulses, 3);
        check("stream_words", words1, 16'd3);
        check("stream_count", delivered.size(), 3);
        for (int i = 0; i < 3; i++)
            check("stream_order", (i < delivered.size()) ? delivered[i] : 8'hxx, 8'h11 * (i + 1));

        // Backpressure
        fifo_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        inc_pulses = 0; delivered.delete();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
        check("bp_incs", inc_pulses, 2);
        check("bp_head", s1.O_DATA, 8'hA0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
        check("bp_count", delivered.size(), 5);
        for (int i = 0; i < 5; i++)
            check("bp_order", (i < delivered.size()) ? delivered[i] : 8'hxx, 8'hA0 + i);
        sat_en = 1'b0;
        check("sat_log_len", sat_log.size(), 5);
        for (int i = 0; i < 5; i++)
            check("sat_seq", (i < sat_log.size()) ? sat_log[i] : 2'bxx, sat_exp[i]);

        // Flush with a full buffer and the FIFO still non-empty
        fifo_q = '{8'h01, 8'h02, 8'h03};
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("pre_flush_full", dbg1, 2'd2);
        step(1'b0, 1'b1);
        delivered.delete();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        check("flush_count", delivered.size(), 1);
        check("flush_next", (delivered.size() > 0) ? delivered[0] : 8'hxx, 8'h03);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if (fifo_q.size() < 8 && $urandom_range(0, 1) == 1) fifo_q.push_back(DW'($urandom));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end

        // Asynchronous reset with a full, stalled buffer
        fifo_q = '{8'h5A, 8'hC3, 8'h7E};
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        check("pre_rst_full", dbg1, 2'd2);
        #2;
        r_rst = 1'b0; r_empty = 1'b1;
        #1;
        check("arst_valid", s1.O_VALID, 1'b0);
        check("arst_words", words1, 16'd0);
        check("arst_words_sat", words2, 2'd0);
        check("arst_data", s1.O_DATA, 8'h00);
        check("arst_inc", r_inc, 1'b0);
        fifo_q.delete(); buf_q.delete(); model_words = 0;
        @(posedge r_clk);
        #1 r_rst = 1'b1;
        fifo_q = '{8'h99, 8'h98};
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
